// File: rtl/mem_wb_writeback_reg_pkg.sv
// Pipeline-register package: default widths, stage control type and the bubble constant.
// The same package backs the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
package mem_wb_writeback_reg_pkg;

  localparam int PIPE_DATA_W = 8;
  localparam int PIPE_ADDR_W = 5;
  localparam int PIPE_CNT_W  = 16;

  typedef struct packed {
    logic valid;
    logic we_top;
    logic we_bot;
  } pipe_ctl_t;

  // All-zero stage contents: an empty slot that never writes anything
  localparam pipe_ctl_t CTL_BUBBLE = '0;

  function automatic pipe_ctl_t ctl_capture(input logic vld, input logic we_t,
                                            input logic we_b);
    pipe_ctl_t c;
    c.valid  = vld;
    c.we_top = we_t & vld;
    c.we_bot = we_b & vld;
    return c;
  endfunction

endpackage

// File: rtl/mem_wb_writeback_reg_wb_history.sv
// wb_history_reg: holds the previously retired writeback data (the tm1 forwarding source).
// Loads only when a valid instruction leaves the MEM/WB stage, so bubbles never overwrite it.
module wb_history_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] top_i,
  input  logic [DATA_W-1:0] bot_i,
  output logic [DATA_W-1:0] top_o,
  output logic [DATA_W-1:0] bot_o
);

  logic [DATA_W-1:0] top_q, top_d;
  logic [DATA_W-1:0] bot_q, bot_d;

  always_comb begin
    top_d = top_q;
    bot_d = bot_q;
    if (cap_i) begin
      top_d = top_i;
      bot_d = bot_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      bot_q <= '0;
    end else begin
      top_q <= top_d;
      bot_q <= bot_d;
    end
  end

  assign top_o = top_q;
  assign bot_o = bot_q;

endmodule

// File: rtl/mem_wb_writeback_reg.sv
// MEM/WB pipeline register and register-file writeback driver with forwarding taps.
// Optional MEM_WB_PERF_CNT_EN adds retire/bubble performance counters.
module mem_wb_writeback_reg
  import mem_wb_writeback_reg_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data_top,
  input  logic [DATA_W-1:0] in_data_bot,
  input  logic [ADDR_W-1:0] in_rd_top,
  input  logic [ADDR_W-1:0] in_rd_bot,
  input  logic              in_we_top,
  input  logic              in_we_bot,
  output logic [DATA_W-1:0] mem_wb_top,
  output logic [DATA_W-1:0] mem_wb_bot,
  output logic [DATA_W-1:0] mem_wb_tm1_top,
  output logic [DATA_W-1:0] mem_wb_tm1_bot,
  output logic              wb_valid,
  output logic              rf_we_top,
  output logic              rf_we_bot,
  output logic [ADDR_W-1:0] rf_addr_top,
  output logic [ADDR_W-1:0] rf_addr_bot,
`ifdef MEM_WB_PERF_CNT_EN
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic              rf_collision
);

  pipe_ctl_t         ctl_q, ctl_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic [DATA_W-1:0] bot_q, bot_d;
  logic [ADDR_W-1:0] rd_top_q, rd_top_d;
  logic [ADDR_W-1:0] rd_bot_q, rd_bot_d;

  logic advance;
  logic shift;

  assign advance = ~stall;
  // Flush overrides stall, so the stage contents move on either event
  assign shift   = advance | flush;

  always_comb begin
    ctl_d    = ctl_q;
    top_d    = top_q;
    bot_d    = bot_q;
    rd_top_d = rd_top_q;
    rd_bot_d = rd_bot_q;
    if (flush) begin
      ctl_d    = CTL_BUBBLE;
      top_d    = '0;
      bot_d    = '0;
      rd_top_d = '0;
      rd_bot_d = '0;
    end else if (advance) begin
      ctl_d    = ctl_capture(in_valid, in_we_top, in_we_bot);
      top_d    = in_data_top;
      bot_d    = in_data_bot;
      rd_top_d = in_rd_top;
      rd_bot_d = in_rd_bot;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctl_q    <= CTL_BUBBLE;
      top_q    <= '0;
      bot_q    <= '0;
      rd_top_q <= '0;
      rd_bot_q <= '0;
    end else begin
      ctl_q    <= ctl_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      rd_top_q <= rd_top_d;
      rd_bot_q <= rd_bot_d;
    end
  end

  wb_history_reg #(.DATA_W(DATA_W)) u_hist (
    .clk   (clock),
    .rst_n (reset_n),
    .cap_i (shift & ctl_q.valid),
    .top_i (top_q),
    .bot_i (bot_q),
    .top_o (mem_wb_tm1_top),
    .bot_o (mem_wb_tm1_bot)
  );

  assign mem_wb_top  = top_q;
  assign mem_wb_bot  = bot_q;
  assign wb_valid    = ctl_q.valid;
  assign rf_addr_top = rd_top_q;
  assign rf_addr_bot = rd_bot_q;

  // Same-address double write: bottom byte wins, top write is dropped
  assign rf_collision = ctl_q.valid & ctl_q.we_top & ctl_q.we_bot & (rd_top_q == rd_bot_q);
  assign rf_we_top    = ctl_q.valid & ctl_q.we_top & ~rf_collision;
  assign rf_we_bot    = ctl_q.valid & ctl_q.we_bot;

`ifdef MEM_WB_PERF_CNT_EN
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    retire_d = retire_q;
    bubble_d = bubble_q;
    if (shift) begin
      if (ctl_q.valid) retire_d = retire_q + 1'b1;
      else             bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      retire_q <= retire_d;
      bubble_q <= bubble_d;
    end
  end

  assign retire_cnt = retire_q;
  assign bubble_cnt = bubble_q;
`endif

endmodule
